// File: rtl/intrument_unit_capture_master.sv
// intrument_unit_capture_master: Avalon-MM write master packing 16-bit samples into 32-bit words, single-shot or ring capture
module intrument_unit_capture_master #(
  parameter int ADDR_W   = 19,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_words,
  input  logic                cfg_ring,
  input  logic                start,
  input  logic                stop,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [3:0]          m_byteenable,
  output logic [31:0]         m_writedata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic [7:0]          wrap_cnt
);
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ptr_q, ptr_d, addr_q, addr_d, last, ptr_nx;
  logic [ADDR_W:0] words_q, words_d, cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic [3:0] be_q, be_d;
  logic [31:0] data_q, data_d;
  logic [7:0] wrap_q, wrap_d;
  logic ring_q, ring_d, half_q, half_d, fin_q, fin_d, wr_q, wr_d, done_q, done_d, busy_q, busy_d, at_last;
  assign last = base_q + words_q[ADDR_W-1:0] - ADDR_W'(1);
  assign at_last = ptr_q == last;
  assign ptr_nx = at_last ? base_q : ptr_q + ADDR_W'(1);
  // fin_q holds the block busy for the cycle carrying the last strobe, so done follows it
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    words_d = words_q;
    ring_d = ring_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    half_d = half_q;
    held_d = held_q;
    fin_d = fin_q;
    wrap_d = wrap_q;
    wr_d = 1'b0;
    addr_d = '0;
    be_d = '0;
    data_d = '0;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && cfg_words != '0) begin
        state_d = CAPTURE;
        base_d = cfg_base;
        words_d = cfg_words;
        ring_d = cfg_ring;
        ptr_d = cfg_base;
        cnt_d = '0;
        half_d = 1'b0;
        wrap_d = '0;
        fin_d = 1'b0;
      end
    end else if (fin_q) begin
      state_d = IDLE;
      done_d = 1'b1;
      fin_d = 1'b0;
      half_d = 1'b0;
    end else if (state_q == FLUSH) begin
      wr_d = 1'b1;
      addr_d = ptr_q;
      be_d = 4'b0011;
      data_d = {{SAMPLE_W{1'b0}}, held_q};
      ptr_d = ptr_nx;
      half_d = 1'b0;
      fin_d = 1'b1;
    end else begin
      if (smp_valid) begin
        half_d = !half_q;
        held_d = half_q ? held_q : smp_data;
        if (half_q) begin
          wr_d = 1'b1;
          addr_d = ptr_q;
          be_d = 4'b1111;
          data_d = {smp_data, held_q};
          ptr_d = ptr_nx;
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          fin_d = !ring_q && cnt_d == words_q;
        end
      end
      if (stop && !fin_d) begin
        if (half_d) state_d = FLUSH;
        else if (wr_d) fin_d = 1'b1;
        else begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
    end
    if (wr_d && ring_q && at_last && wrap_q != 8'hff) wrap_d = wrap_q + 8'd1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      words_q <= '0;
      ring_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
      half_q <= 1'b0;
      held_q <= '0;
      fin_q <= 1'b0;
      wrap_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      words_q <= words_d;
      ring_q <= ring_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      half_q <= half_d;
      held_q <= held_d;
      fin_q <= fin_d;
      wrap_q <= wrap_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      be_q <= be_d;
      data_q <= data_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign m_address = addr_q;
  assign m_chipselect = wr_q;
  assign m_write = wr_q;
  assign m_byteenable = be_q;
  assign m_writedata = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wr_ptr = ptr_q;
  assign wrap_cnt = wrap_q;
endmodule

// File: tb/tb_intrument_unit_capture_master.sv
// tb_intrument_unit_capture_master: randomized capture scenarios checked against a sample-list reference model
module tb_intrument_unit_capture_master;
  logic clk = 0, reset = 1;
  logic [18:0] cfg_base = '0;
  logic [19:0] cfg_words = '0;
  logic cfg_ring = 0, start = 0, stop = 0, smp_valid = 0;
  logic [15:0] smp_data = '0;
  logic [18:0] m_address, wr_ptr;
  logic m_chipselect, m_write, busy, done;
  logic [3:0] m_byteenable;
  logic [31:0] m_writedata;
  logic [7:0] wrap_cnt;
  int cyc = 0, errors = 0, checks = 0;
  logic [18:0] wa[$], wp[$];
  logic [31:0] wd[$];
  logic [3:0] wb[$];
  logic [7:0] ww[$];
  int wc[$], dc[$], sc[$];
  logic dbusy[$], dprev[$];
  logic busy_prev = 0;
  logic [15:0] smp_q[$];

  intrument_unit_capture_master dut (
    .clk(clk), .reset(reset), .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_ring(cfg_ring),
    .start(start), .stop(stop), .smp_valid(smp_valid), .smp_data(smp_data),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .busy(busy), .done(done),
    .wr_ptr(wr_ptr), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    checks++;
    if (m_chipselect !== m_write || (m_write !== 1'b1 && (m_byteenable !== 4'h0 || m_writedata !== 32'h0))) begin
      errors++;
      $display("FAIL strobe_idle cyc=%0d: cs=%b wr=%b be=%h data=%h, required cs==wr and be/data 0 when idle",
               cyc, m_chipselect, m_write, m_byteenable, m_writedata);
    end
    if (m_write === 1'b1) begin
      wa.push_back(m_address); wd.push_back(m_writedata); wb.push_back(m_byteenable);
      wc.push_back(cyc); wp.push_back(wr_ptr); ww.push_back(wrap_cnt);
    end
    if (done === 1'b1) begin
      dc.push_back(cyc); dbusy.push_back(busy); dprev.push_back(busy_prev);
    end
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cfg_base = 19'($urandom);
    cfg_words = 20'($urandom_range(0, 40));
    cfg_ring = 1'($urandom);
    smp_data = 16'($urandom);
  endtask

  function automatic logic [7:0] sat(input int v);
    return v > 255 ? 8'hff : 8'(v);
  endfunction

  task automatic clear_mon();
    wa.delete(); wd.delete(); wb.delete(); wc.delete(); wp.delete(); ww.delete();
    dc.delete(); dbusy.delete(); dprev.delete(); sc.delete();
  endtask

  // stop_mode: 0 none (single-shot runs to completion), 1 stop the cycle after the last sample, 2 stop with the last sample
  task automatic run_scenario(input string name, input logic [18:0] base, input logic [19:0] words,
                              input logic ring, input int gap, input int stop_mode);
    int n, npairs, nexp, st, g, ec, ed_cyc;
    logic flush;
    logic [18:0] ea, ep;
    logic [31:0] ed;
    logic [3:0] eb;
    logic [7:0] ew;
    clear_mon();
    n = smp_q.size();
    cfg_base = base; cfg_words = words; cfg_ring = ring; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < n; i++) begin
      g = gap < 0 ? $urandom_range(0, 4) : gap;
      if (i > 0) repeat (g) begin scramble(); tick(); end
      scramble();
      smp_valid = 1; smp_data = smp_q[i]; sc.push_back(cyc);
      if (stop_mode == 2 && i == n - 1) stop = 1;
      if (ring && i < n - 1 && $urandom_range(0, 3) == 0) start = 1;
      tick();
      smp_valid = 0; stop = 0; start = 0;
    end
    st = stop_mode == 2 ? sc[n-1] : cyc;
    if (stop_mode == 1) begin stop = 1; tick(); stop = 0; end
    repeat (8) begin scramble(); tick(); end
    npairs = n / 2;
    if (!ring && stop_mode == 0 && npairs > int'(words)) npairs = int'(words);
    flush = stop_mode != 0 && n % 2 == 1;
    nexp = npairs + int'(flush);
    checks++;
    if (wa.size() != nexp) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wa.size(), nexp);
    end
    for (int k = 0; k < nexp && k < wa.size(); k++) begin
      ea = base + 19'(k % int'(words));
      ep = base + 19'((k + 1) % int'(words));
      ew = ring ? sat((k + 1) / int'(words)) : 8'h0;
      if (k < npairs) begin
        ed = {smp_q[2*k+1], smp_q[2*k]}; eb = 4'hf; ec = sc[2*k+1] + 1;
      end else begin
        ed = {16'h0, smp_q[n-1]}; eb = 4'h3; ec = st + 2;
      end
      checks++;
      if (wa[k] !== ea || wd[k] !== ed || wb[k] !== eb) begin
        errors++;
        $display("FAIL %s write%0d addr/data/be: got %h/%h/%h required %h/%h/%h", name, k, wa[k], wd[k], wb[k], ea, ed, eb);
      end
      checks++;
      if (wc[k] != ec || wp[k] !== ep || ww[k] !== ew) begin
        errors++;
        $display("FAIL %s write%0d cyc/wr_ptr/wrap: got %0d/%h/%0d required %0d/%h/%0d", name, k, wc[k], wp[k], ww[k], ec, ep, ew);
      end
    end
    if (stop_mode == 0) ed_cyc = sc[2*npairs-1] + 2;
    else if (flush) ed_cyc = st + 3;
    else if (stop_mode == 2) ed_cyc = st + 2;
    else ed_cyc = st + 1;
    checks++;
    if (dc.size() != 1 || dc[0] != ed_cyc || dbusy[0] !== 1'b0 || dprev[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got count=%0d cyc=%0d busy=%b prev_busy=%b required count=1 cyc=%0d busy=0 prev_busy=1",
               name, dc.size(), dc.size() > 0 ? dc[0] : -1, dbusy.size() > 0 ? dbusy[0] : 1'bx,
               dprev.size() > 0 ? dprev[0] : 1'bx, ed_cyc);
    end
    ep = base + 19'(nexp % int'(words));
    ew = ring ? sat(nexp / int'(words)) : 8'h0;
    checks++;
    if (wr_ptr !== ep || wrap_cnt !== ew || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s final: got wr_ptr=%h wrap=%0d busy=%b required %h/%0d/0", name, wr_ptr, wrap_cnt, busy, ep, ew);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    checks++;
    if ({m_write, m_chipselect, m_byteenable, m_writedata, m_address, busy, done, wr_ptr, wrap_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got wr=%b be=%h data=%h addr=%h busy=%b done=%b ptr=%h wrap=%0d required all 0",
               m_write, m_byteenable, m_writedata, m_address, busy, done, wr_ptr, wrap_cnt);
    end
  endtask

  task automatic test_single_shot();
    smp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_scenario("single_shot", 19'h00010, 20'd2, 1'b0, 0, 0);
  endtask

  task automatic test_ring_wrap();
    smp_q.delete();
    repeat (8) smp_q.push_back(16'($urandom));
    run_scenario("ring_wrap", 19'h7FFFE, 20'd3, 1'b1, 0, 1);
  endtask

  task automatic test_partial_flush();
    smp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_scenario("partial_flush", 19'h01230, 20'd8, 1'b1, 0, 1);
  endtask

  task automatic test_stop_with_sample();
    smp_q = '{16'h1234, 16'h5678, 16'hCAFE, 16'hBEEF};
    run_scenario("stop_with_sample", 19'h00400, 20'd16, 1'b1, 1, 2);
    smp_q = '{16'h0001, 16'h0002, 16'hBEEF};
    run_scenario("stop_with_odd_sample", 19'h00500, 20'd16, 1'b1, 0, 2);
  endtask

  task automatic test_sparse();
    smp_q.delete();
    repeat (8) smp_q.push_back(16'($urandom));
    run_scenario("sparse", 19'h00200, 20'd4, 1'b0, 4, 0);
  endtask

  task automatic test_full_window();
    smp_q.delete();
    repeat (7) smp_q.push_back(16'($urandom));
    run_scenario("full_window", 19'h7FFFF, 20'h80000, 1'b0, -1, 1);
  endtask

  task automatic test_wrap_saturate();
    smp_q.delete();
    repeat (520) smp_q.push_back(16'($urandom));
    run_scenario("wrap_saturate", 19'h0ABCD, 20'd1, 1'b1, 0, 1);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    cfg_base = 19'h00123; cfg_words = 20'd5; cfg_ring = 1; start = 1;
    tick();
    start = 0;
    repeat (3) begin smp_valid = 1; smp_data = 16'($urandom); tick(); end
    smp_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({m_write, m_chipselect, m_byteenable, m_writedata, m_address, busy, done, wr_ptr, wrap_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got wr=%b be=%h data=%h busy=%b done=%b ptr=%h wrap=%0d required all 0",
               m_write, m_byteenable, m_writedata, busy, done, wr_ptr, wrap_cnt);
    end
    repeat (4) tick();
    cfg_words = 20'd0; start = 1;
    tick();
    start = 0;
    checks++;
    if (busy !== 1'b0 || wr_ptr !== 19'h0) begin
      errors++;
      $display("FAIL start_zero_words: got busy=%b wr_ptr=%h required busy=0 wr_ptr=0", busy, wr_ptr);
    end
    repeat (4) begin smp_valid = 1; smp_data = 16'($urandom); tick(); end
    smp_valid = 0;
    repeat (3) tick();
    checks++;
    if (wa.size() != 1 || dc.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_writes: got writes=%0d dones=%0d required writes=1 dones=0", wa.size(), dc.size());
    end
  endtask

  task automatic test_random();
    logic r;
    int w, n, sm;
    for (int it = 0; it < 8; it++) begin
      r = 1'($urandom);
      w = $urandom_range(1, 6);
      n = r ? $urandom_range(1, 20) : 2 * w + $urandom_range(0, 2);
      sm = r ? $urandom_range(1, 2) : 0;
      smp_q.delete();
      repeat (n) smp_q.push_back(16'($urandom));
      run_scenario("random", 19'($urandom), 20'(w), r, -1, sm);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_ring_wrap();
    test_partial_flush();
    test_stop_with_sample();
    test_sparse();
    test_full_window();
    test_wrap_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intrument_unit_capture_master.md
# intrument_unit_capture_master

Avalon-MM write master that packs a 16-bit instrument sample stream into 32-bit words. It writes those words into the dual-port on-chip sample memory through that memory's second slave port. It supports single-shot capture of N words or continuous ring-buffer capture over a configurable window. It sits between the acquisition front end and the memory; the Nios side reads results through the other port.

## Interface
Parameters:
- ADDR_W, 19, word-address width of the memory port
- SAMPLE_W, 16, sample width; two samples per 32-bit word (fixed ratio)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_base  in  ADDR_W  first word address of capture window
- cfg_words  in  ADDR_W+1  window length in words, 1..2^ADDR_W; 0 invalid
- cfg_ring  in  1  0 = single-shot, 1 = continuous ring
- start  in  1  one-cycle pulse, begins capture
- stop  in  1  one-cycle pulse, ends capture
- smp_valid  in  1  sample strobe, at most one per cycle, no backpressure
- smp_data  in  SAMPLE_W  sample value
- m_address  out  ADDR_W  word address to memory
- m_chipselect  out  1  asserted together with m_write
- m_write  out  1  write strobe, one cycle per word
- m_byteenable  out  4  lane enables
- m_writedata  out  32  packed data, first sample in [15:0]
- busy  out  1  high in CAPTURE and FLUSH
- done  out  1  one-cycle completion pulse
- wr_ptr  out  ADDR_W  address the next word will be written to
- wrap_cnt  out  8  ring wrap count, saturates at 255

## Operation
States: IDLE, CAPTURE, FLUSH.

IDLE:
- start with cfg_words != 0 latches cfg_base, cfg_words and cfg_ring, then enters CAPTURE.
- On entry, ptr = base, word count = 0, half = 0, wrap_cnt = 0.
- start with cfg_words == 0 is ignored.
- smp_valid is ignored.

CAPTURE:
- smp_valid with half=0: hold the sample, set half=1.
- smp_valid with half=1: write {smp_data, held} to ptr with byteenable 4'b1111, set half=0, advance ptr.
- Pointer advance: if ptr == base+cfg_words-1, ptr returns to base. All address arithmetic is modulo 2^ADDR_W, so a window may cross the top of memory.
- Single-shot: after the cfg_words-th write, go to IDLE and pulse done.
- Ring: at each return to base, increment wrap_cnt (saturating). Capture continues until stop.
- stop with half=0: go to IDLE and pulse done.
- stop with half=1: go to FLUSH.
- stop and smp_valid in the same cycle: the sample is accepted first, then stop is evaluated against the updated half.
- start while busy is ignored. Config inputs are not sampled outside the start cycle.

FLUSH:
- Write {16'h0000, held} to ptr with byteenable 4'b0011.
- Advance ptr using the same wrap rules.
- Go to IDLE and pulse done.

Reset:
- All outputs, registers and state clear to 0 / IDLE on the next clk edge.
- A held partial sample is discarded and no write is issued.

## Timing
- All outputs are registered.
- m_write, m_chipselect, m_address, m_byteenable and m_writedata are valid for exactly one cycle. That cycle is the one after the completing sample, or the FLUSH cycle.
- m_chipselect equals m_write. When no write is issued, m_byteenable and m_writedata are 0.
- The memory has no waitrequest: every strobe is accepted. Maximum rate is one write per two cycles.
- wr_ptr and wrap_cnt update in the same cycle as the corresponding m_write.
- done is asserted in the cycle after the final write strobe. For a stop with no partial word, done is asserted in the cycle after stop.
- busy deasserts in the same cycle done asserts.
- Read-back is not this block's job. The slave's one-cycle read latency is irrelevant here.

## Test plan
- Single-shot, no wrap: base=0x00010, words=2, ring=0; samples 0x1111,0x2222,0x3333,0x4444 back-to-back -> writes 0x22221111 @0x00010 and 0x44443333 @0x00011, all BE=1111; done one cycle after the second write; fifth sample produces no write.
- Ring wrap: base=0x7FFFE, words=3, ring=1; 8 samples -> addresses 0x7FFFE, 0x7FFFF, 0x00000, then 0x7FFFE; wrap_cnt=1 after the fourth write.
- Partial flush: ring=1; samples 0xAAAA,0xBBBB,0xCCCC, then stop -> second write {0x0000,0xCCCC} with BE=0011; done the next cycle; wr_ptr = base+2.
- Simultaneous stop and smp_valid: smp_valid=0xBEEF completes a word in the same cycle as stop -> one full write, no flush write, done the cycle after.
- Reset mid-capture: reset asserted with half=1 -> no write issued; all outputs 0, busy=0 next cycle; start ignored while cfg_words=0.
- Sparse samples: smp_valid every 5th cycle, words=4 -> exactly 4 one-cycle strobes at consecutive addresses; data pairs in sample order.
